// File: rtl/regfile_pkg.sv
// Shared register-file definitions: architectural sizes and the
// debug dump controller state encoding.
package regfile_pkg;

    localparam int REG_ADDR_WIDTH = 5;
    localparam int REG_DATA_WIDTH = 32;
    localparam int NUM_ARCH_REGS  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } dump_state_t;

endpackage

// File: rtl/regfile_dump_ctrl.sv
// Debug dump controller: walks register addresses 0..NUM_REGS-1 on the
// register file debug read port and streams {addr, data} beats.
//
// Ports:
//   clock, reset      system clock, async active-high reset
//   start, abort      request / cancel a dump
//   dbg_addr/dbg_data register file debug read port (comb read)
//   out_valid/ready   beat handshake, out_addr/out_data beat payload
//   busy              high while fetching or sending
//   done              one-cycle pulse after the last beat is accepted
module regfile_dump_ctrl
    import regfile_pkg::*;
#(
    parameter int NUM_REGS   = NUM_ARCH_REGS,
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
    parameter int DATA_WIDTH = REG_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX =
        ADDR_WIDTH'(NUM_REGS - 1);

    dump_state_t           state;
    dump_state_t           state_n;
    logic [ADDR_WIDTH-1:0] index;

    logic idx_clr;
    logic idx_inc;
    logic load_beat;
    logic drop_valid;
    logic handshake;

    assign handshake = out_valid && out_ready;

    // The index register drives the read port directly, so the address
    // is registered and simply holds once the walk stops.
    assign dbg_addr = index;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        idx_clr    = 1'b0;
        idx_inc    = 1'b0;
        load_beat  = 1'b0;
        drop_valid = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                // abort wins over a simultaneous start
                if (start && !abort) begin
                    idx_clr = 1'b1;
                    state_n = FETCH;
                end
            end
            FETCH: begin
                busy = 1'b1;
                if (abort) begin
                    state_n = IDLE;
                end else begin
                    load_beat = 1'b1;
                    state_n   = SEND;
                end
            end
            SEND: begin
                busy = 1'b1;
                // abort wins over a same-cycle handshake
                if (abort) begin
                    drop_valid = 1'b1;
                    state_n    = IDLE;
                end else if (handshake) begin
                    drop_valid = 1'b1;
                    if (index == LAST_IDX) begin
                        state_n = DONE;
                    end else begin
                        idx_inc = 1'b1;
                        state_n = FETCH;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            index <= '0;
        end else if (idx_clr) begin
            index <= '0;
        end else if (idx_inc) begin
            index <= index + ADDR_WIDTH'(1);
        end
    end

    // Payload is captured once per FETCH and then held untouched until
    // the beat is taken, so backpressure never disturbs it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
        end else if (load_beat) begin
            out_valid <= 1'b1;
            out_addr  <= index;
            out_data  <= dbg_data;
        end else if (drop_valid) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Self-checking bench for regfile_dump_ctrl with a behavioural
// register file on the debug port.
module tb_regfile_dump_ctrl;
    import regfile_pkg::*;

    localparam int N  = NUM_ARCH_REGS;
    localparam int AW = REG_ADDR_WIDTH;
    localparam int DW = REG_DATA_WIDTH;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          done;

    logic [DW-1:0] rf [N];
    logic [DW-1:0] exp_d [N];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    assign dbg_data = rf[dbg_addr];

    regfile_dump_ctrl #(
        .NUM_REGS  (N),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_addr (out_addr),
        .out_data (out_data),
        .busy     (busy),
        .done     (done)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 64'(out_valid), 0);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_done"}, 64'(done), 0);
        chk({tag, "_oaddr"}, 64'(out_addr), 0);
        chk({tag, "_odata"}, 64'(out_data), 0);
        chk({tag, "_dbg"}, 64'(dbg_addr), 0);
    endtask

    // mode 0: ready high, 1: random ready, 2: stall beat 5 three cycles
    task automatic run_dump(input int mode, input bit do_write,
                            input bit restart10);
        int      cyc;
        int      beats;
        int      stalls;
        int      next_v;
        int      hold5;
        int      seen5;
        bit      prev_stall;
        bit      prev_valid;
        bit      written;
        bit      rdy;
        bit      got_done;
        logic [AW-1:0] pa;
        logic [DW-1:0] pd;
        cyc = 0; beats = 0; stalls = 0; next_v = 0;
        hold5 = 0; seen5 = 0; got_done = 0;
        prev_stall = 0; prev_valid = 0; written = 0;
        pa = '0; pd = '0;
        start = 1'b1;
        step();
        start = 1'b0;
        while (1) begin
            if (cyc > 1000) begin
                errors++;
                $display("FAIL dump_timeout: beats %0d", beats);
                break;
            end
            if (done) begin
                got_done = 1;
                chk("done_latency", 64'(cyc), 64'(2 * N + stalls));
                chk("busy_at_done", 64'(busy), 0);
                break;
            end
            chk("busy_in_dump", 64'(busy), 1);
            if (prev_stall) begin
                chk("hold_valid", 64'(out_valid), 1);
                chk("hold_addr", 64'(out_addr), 64'(pa));
                chk("hold_data", 64'(out_data), 64'(pd));
            end
            if (out_valid && !prev_valid) begin
                if (beats == 0) chk("first_valid", 64'(cyc), 1);
                else chk("beat_gap", 64'(cyc), 64'(next_v));
            end
            if (mode == 1) begin
                rdy = 1'($urandom_range(0, 1));
            end else if (mode == 2 && out_valid && out_addr == 5 &&
                         hold5 < 3) begin
                rdy = 0;
                hold5++;
            end else begin
                rdy = 1;
            end
            out_ready = rdy;
            if (out_valid && out_addr == 5) seen5++;
            start = restart10 && out_valid && out_addr == 10;
            if (do_write && !written && out_valid && out_addr == 3) begin
                rf[20]  = 32'hDEADBEEF;
                rf[2]   = 32'hDEADBEEF;
                written = 1;
            end
            prev_valid = out_valid;
            prev_stall = out_valid && !rdy;
            pa = out_addr;
            pd = out_data;
            if (out_valid && rdy) begin
                chk("beat_addr", 64'(out_addr), 64'(beats));
                chk("beat_data", 64'(out_data), 64'(exp_d[beats % N]));
                beats++;
                next_v = cyc + 2;
            end else if (out_valid) begin
                stalls++;
            end
            step();
            cyc++;
        end
        start = 1'b0;
        out_ready = 1'b0;
        chk("done_seen", 64'(got_done), 1);
        chk("beat_count", 64'(beats), 64'(N));
        if (mode == 2) chk("stall5_cycles", 64'(seen5), 4);
        step();
        chk("done_once", 64'(done), 0);
        chk("idle_busy", 64'(busy), 0);
    endtask

    typedef struct {
        logic          s;
        logic          a;
        logic          r;
        logic          ev;
        logic          eb;
        logic [AW-1:0] edbg;
        logic          cb;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
    } vec_t;

    vec_t vt [10];

    initial begin
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) rf[i] = DW'(i);
        #2;
        chk_zero("reset");
        #10;
        reset = 1'b0;
        step();
        chk_zero("post_reset");

        // start/abort corners applied one cycle at a time
        vt[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[1] = '{1, 1, 0, 0, 0, 0, 0, 0, 0};
        vt[2] = '{1, 0, 0, 0, 1, 0, 0, 0, 0};
        vt[3] = '{0, 0, 0, 1, 1, 0, 1, 0, 0};
        vt[4] = '{0, 0, 1, 0, 1, 1, 0, 0, 0};
        vt[5] = '{0, 0, 0, 1, 1, 1, 1, 1, 1};
        vt[6] = '{0, 1, 1, 0, 0, 1, 0, 0, 0};
        vt[7] = '{0, 0, 1, 0, 0, 1, 0, 0, 0};
        vt[8] = '{1, 0, 0, 0, 1, 0, 0, 0, 0};
        vt[9] = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 10; i++) begin
            start = vt[i].s;
            abort = vt[i].a;
            out_ready = vt[i].r;
            step();
            chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(vt[i].ev));
            chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(vt[i].eb));
            chk($sformatf("vec%0d_done", i), 64'(done), 0);
            chk($sformatf("vec%0d_dbg", i), 64'(dbg_addr), 64'(vt[i].edbg));
            if (vt[i].cb) begin
                chk($sformatf("vec%0d_oaddr", i), 64'(out_addr), 64'(vt[i].ea));
                chk($sformatf("vec%0d_odata", i), 64'(out_data), 64'(vt[i].ed));
            end
        end
        start = 1'b0;
        abort = 1'b0;
        out_ready = 1'b0;
        step();

        for (int i = 0; i < N; i++) exp_d[i] = DW'(i);
        run_dump(0, 0, 0);
        run_dump(2, 0, 0);
        run_dump(0, 0, 1);
        run_dump(0, 0, 0);

        // abort at beat 7 together with a handshake
        start = 1'b1;
        step();
        start = 1'b0;
        begin
            int n;
            n = 0;
            out_ready = 1'b1;
            while (!(out_valid && out_addr == 7) && n < 200) begin
                step();
                n++;
            end
            chk("abort_reach7", 64'(n < 200), 1);
        end
        abort = 1'b1;
        out_ready = 1'b1;
        step();
        abort = 1'b0;
        out_ready = 1'b0;
        chk("abort_valid", 64'(out_valid), 0);
        chk("abort_busy", 64'(busy), 0);
        begin
            int dn;
            dn = 0;
            for (int k = 0; k < 4; k++) begin
                if (done) dn++;
                step();
            end
            chk("abort_no_done", 64'(dn), 0);
        end
        chk("abort_idle", 64'(busy), 0);

        // asynchronous reset during beat 12
        start = 1'b1;
        step();
        start = 1'b0;
        begin
            int n;
            n = 0;
            out_ready = 1'b1;
            while (!(out_valid && out_addr == 12) && n < 200) begin
                step();
                n++;
            end
            chk("rst_reach12", 64'(n < 200), 1);
        end
        out_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk_zero("async_rst");
        @(negedge clock);
        reset = 1'b0;
        step();
        chk_zero("rst_release");
        run_dump(0, 0, 0);

        // writes during the dump: reg 20 not yet read, reg 2 already sent
        exp_d[20] = 32'hDEADBEEF;
        run_dump(0, 1, 0);
        for (int i = 0; i < N; i++) rf[i] = DW'(i);

        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < N; i++) begin
                rf[i]    = $urandom;
                exp_d[i] = rf[i];
            end
            run_dump(1, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
